// File: rtl/infrared_tx.sv
// Serial IR frame transmitter: sends {addr, cmd, ~cmd} MSB-first on E, framed by
// a low start bit, a high stop bit and an optional idle gap.
module infrared_tx #(
  parameter int BIT_CYCLES = 1,
  parameter int GAP_BITS   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] addr,
  input  logic [7:0]  cmd,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        E,
  output logic [2:0]  estado,
  output logic [5:0]  i_out,
  output logic [31:0] reg_E_out
);

  localparam int BW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t          state_r, state_s;
  logic [BW-1:0]   bcnt_r, bcnt_s;
  logic [GW-1:0]   gcnt_r, gcnt_s;
  logic [5:0]      idx_r, idx_s;
  logic [31:0]     frame_r, frame_s;
  logic            e_r, e_s;
  logic            done_r, done_s;
  logic            period_end_s;

  function automatic logic [31:0] build_frame(input logic [15:0] a, input logic [7:0] c);
    build_frame = {a, c, ~c};
  endfunction

  assign period_end_s = (bcnt_r == BW'(BIT_CYCLES - 1));

  // Next-state, counter and line-level decode; E is computed from the next state
  // so the registered line changes on the same edge as the state.
  always_comb begin
    state_s = state_r;
    bcnt_s  = period_end_s ? BW'(0) : bcnt_r + BW'(1);
    gcnt_s  = gcnt_r;
    idx_s   = idx_r;
    frame_s = frame_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        bcnt_s = BW'(0);
        gcnt_s = GW'(0);
        idx_s  = 6'd0;
        if (start) begin
          frame_s = build_frame(addr, cmd);
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (period_end_s) begin
          state_s = ST_DATA;
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (period_end_s && (idx_r == 6'd31)) begin
          state_s = ST_STOP;
        end else if (period_end_s) begin
          idx_s = idx_r + 6'd1;
        end else begin
          idx_s = idx_r;
        end
      end
      ST_STOP: begin
        if (period_end_s) begin
          done_s = 1'b1;
          gcnt_s = GW'(0);
          if (GAP_BITS == 0) begin
            state_s = ST_IDLE;
            idx_s   = 6'd0;
          end else begin
            state_s = ST_GAP;
          end
        end else begin
          state_s = ST_STOP;
        end
      end
      ST_GAP: begin
        if (period_end_s && (gcnt_r == GW'(GAP_BITS - 1))) begin
          state_s = ST_IDLE;
          idx_s   = 6'd0;
        end else if (period_end_s) begin
          gcnt_s = gcnt_r + GW'(1);
        end else begin
          gcnt_s = gcnt_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        bcnt_s  = BW'(0);
        gcnt_s  = GW'(0);
        idx_s   = 6'd0;
      end
    endcase

    case (state_s)
      ST_START: e_s = 1'b0;
      ST_DATA:  e_s = frame_s[5'd31 - idx_s[4:0]];
      default:  e_s = 1'b1;
    endcase
  end

  // State, counters, frame and registered line; reset parks E high at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      bcnt_r  <= BW'(0);
      gcnt_r  <= GW'(0);
      idx_r   <= 6'd0;
      frame_r <= 32'd0;
      e_r     <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      bcnt_r  <= bcnt_s;
      gcnt_r  <= gcnt_s;
      idx_r   <= idx_s;
      frame_r <= frame_s;
      e_r     <= e_s;
      done_r  <= done_s;
    end
  end

  assign ready     = (state_r == ST_IDLE);
  assign busy      = (state_r != ST_IDLE);
  assign done      = done_r;
  assign E         = e_r;
  assign estado    = state_r;
  assign i_out     = idx_r;
  assign reg_E_out = frame_r;

endmodule

// File: tb/tb_infrared_tx.sv
// Directed/randomized bench for infrared_tx: three instances cover BIT_CYCLES/GAP_BITS
// corners; expected line levels come from the frame timing rules computed per cycle.
module tb_infrared_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_v  [3];
  logic [15:0] addr_v   [3];
  logic [7:0]  cmd_v    [3];
  logic        ready_v  [3];
  logic        busy_v   [3];
  logic        done_v   [3];
  logic        e_v      [3];
  logic [2:0]  est_v    [3];
  logic [5:0]  idx_v    [3];
  logic [31:0] frm_v    [3];

  int checks   = 0;
  int failures = 0;

  infrared_tx #(.BIT_CYCLES(1), .GAP_BITS(2)) u0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .addr(addr_v[0]), .cmd(cmd_v[0]),
    .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]), .E(e_v[0]),
    .estado(est_v[0]), .i_out(idx_v[0]), .reg_E_out(frm_v[0]));

  infrared_tx #(.BIT_CYCLES(4), .GAP_BITS(2)) u1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .addr(addr_v[1]), .cmd(cmd_v[1]),
    .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]), .E(e_v[1]),
    .estado(est_v[1]), .i_out(idx_v[1]), .reg_E_out(frm_v[1]));

  infrared_tx #(.BIT_CYCLES(1), .GAP_BITS(0)) u2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .addr(addr_v[2]), .cmd(cmd_v[2]),
    .ready(ready_v[2]), .busy(busy_v[2]), .done(done_v[2]), .E(e_v[2]),
    .estado(est_v[2]), .i_out(idx_v[2]), .reg_E_out(frm_v[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One frame on instance d. The inputs are presented, the acceptance edge is taken,
  // then every cycle up to the return of ready is compared with the timing rules.
  task automatic run_frame(input int d, input int bc, input int gb,
                           input logic [15:0] a, input logic [7:0] c,
                           input bit hold, input int inject_t, input int abort_t);
    logic [31:0] f;
    int          ex_state, ex_idx, bitn;
    logic        ex_e;
    f = 32'(a) * 32'd65536 + 32'(c) * 32'd256 + (32'd255 - 32'(c));
    start_v[d] = 1'b1;
    addr_v[d]  = a;
    cmd_v[d]   = c;
    @(posedge clk); #1;
    start_v[d] = hold;
    addr_v[d]  = 16'($urandom);
    cmd_v[d]   = 8'($urandom);
    for (int t = 0; t <= (34 + gb) * bc; t++) begin
      if (t > 0) begin
        @(posedge clk); #1;
      end
      if (t < bc) begin
        ex_state = 1; ex_idx = 0; ex_e = 1'b0;
      end else if (t < 33 * bc) begin
        bitn = t / bc - 1;
        ex_state = 2; ex_idx = bitn; ex_e = 1'b1 & (f >> (31 - bitn));
      end else if (t < 34 * bc) begin
        ex_state = 3; ex_idx = 31; ex_e = 1'b1;
      end else if (t < (34 + gb) * bc) begin
        ex_state = 4; ex_idx = 31; ex_e = 1'b1;
      end else begin
        ex_state = 0; ex_idx = 0; ex_e = 1'b1;
      end
      chk("E", 32'(e_v[d]), 32'(ex_e));
      chk("estado", 32'(est_v[d]), 32'(ex_state));
      chk("i_out", 32'(idx_v[d]), 32'(ex_idx));
      chk("done", 32'(done_v[d]), 32'(t == 34 * bc));
      chk("ready", 32'(ready_v[d]), 32'(t >= (34 + gb) * bc));
      chk("busy", 32'(busy_v[d]), 32'(t < (34 + gb) * bc));
      chk("reg_E_out", frm_v[d], f);
      if (t == inject_t) begin
        start_v[d] = 1'b1;
        addr_v[d]  = 16'hFFFF;
      end else begin
        start_v[d] = hold;
      end
      if (t == abort_t) begin
        #2 reset = 1'b1;
        #1;
        chk("E_async_reset", 32'(e_v[d]), 32'd1);
        chk("estado_async_reset", 32'(est_v[d]), 32'd0);
        #1 reset = 1'b0;
        start_v[d] = 1'b0;
        @(posedge clk); #1;
        chk("done_after_reset", 32'(done_v[d]), 32'd0);
        chk("ready_after_reset", 32'(ready_v[d]), 32'd1);
        chk("reg_after_reset", frm_v[d], 32'd0);
        return;
      end
    end
  endtask

  task automatic idle_check(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("idle_E", 32'(e_v[d]), 32'd1);
      chk("idle_ready", 32'(ready_v[d]), 32'd1);
      chk("idle_done", 32'(done_v[d]), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start_v[d] = 1'b0;
      addr_v[d]  = 16'd0;
      cmd_v[d]   = 8'd0;
    end
    #22;
    for (int d = 0; d < 3; d++) begin
      chk("rst_E", 32'(e_v[d]), 32'd1);
      chk("rst_ready", 32'(ready_v[d]), 32'd1);
      chk("rst_busy", 32'(busy_v[d]), 32'd0);
      chk("rst_done", 32'(done_v[d]), 32'd0);
      chk("rst_estado", 32'(est_v[d]), 32'd0);
      chk("rst_i_out", 32'(idx_v[d]), 32'd0);
      chk("rst_reg", frm_v[d], 32'd0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic frame with the known 0x00000CF3 pattern.
    run_frame(0, 1, 2, 16'h0000, 8'h0C, 1'b0, -1, -1);
    chk("basic_reg", frm_v[0], 32'h00000CF3);
    idle_check(0, 2);

    for (int i = 0; i < 3; i++) begin
      run_frame(0, 1, 2, 16'($urandom), 8'($urandom), 1'b0, -1, -1);
    end

    // Start pulse with addr=FFFF during DATA must leave the frame and line alone.
    run_frame(0, 1, 2, 16'($urandom), 8'($urandom), 1'b0, 12, -1);
    idle_check(0, 5);

    // Asynchronous reset while data bit 10 (a zero, from addr=0) is on the line.
    run_frame(0, 1, 2, 16'h0000, 8'($urandom), 1'b0, -1, 11);
    idle_check(0, 3);
    run_frame(0, 1, 2, 16'($urandom), 8'($urandom), 1'b0, -1, -1);

    // Back-to-back with start held: each frame is checked from its acceptance edge,
    // so the spacing is enforced by the ready/E expectations of consecutive calls.
    run_frame(1, 4, 2, 16'($urandom), 8'($urandom), 1'b1, -1, -1);
    run_frame(1, 4, 2, 16'($urandom), 8'($urandom), 1'b1, -1, -1);
    run_frame(1, 4, 2, 16'($urandom), 8'($urandom), 1'b0, -1, -1);
    idle_check(1, 4);

    // Zero gap: GAP state never appears and frames start 35 cycles apart.
    run_frame(2, 1, 0, 16'($urandom), 8'($urandom), 1'b1, -1, -1);
    run_frame(2, 1, 0, 16'($urandom), 8'($urandom), 1'b1, -1, -1);
    run_frame(2, 1, 0, 16'($urandom), 8'($urandom), 1'b0, -1, -1);
    idle_check(2, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
